// File: rtl/lag_scan_scheduler.sv
// Lag sweep sequencer: dwells on each lag step, requests a readout frame, then advances every
// enabled channel through one shared adder/comparator. Optional build macro: SCAN_WRAP_EN.
module lag_scan_scheduler #(
  parameter int NUM_INPUTS  = 8,
  parameter int LAG_WIDTH   = 20,
  parameter int INC_WIDTH   = 12,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                            intclk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic                            capture,
  input  logic [NUM_INPUTS-1:0]           scan_en,
  input  logic [NUM_INPUTS*LAG_WIDTH-1:0] start_a,
  input  logic [NUM_INPUTS*LAG_WIDTH-1:0] len_a,
  input  logic [NUM_INPUTS*INC_WIDTH-1:0] increment_a,
  input  logic [DWELL_WIDTH-1:0]          dwell,
  input  logic                            frame_ack,
  output logic [NUM_INPUTS*LAG_WIDTH-1:0] current_a,
  output logic                            frame_req,
  output logic                            scan_done,
  output logic                            busy
);

  localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int SUM_W = LAG_WIDTH + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_INPUTS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DWELL   = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]             state;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic [PTR_W-1:0]       ptr;
  logic [NUM_INPUTS-1:0]  finished;
  logic [LAG_WIDTH-1:0]   cur [NUM_INPUTS];

  logic [LAG_WIDTH-1:0]   sel_cur;
  logic [LAG_WIDTH-1:0]   sel_start;
  logic [LAG_WIDTH-1:0]   sel_len;
  logic [INC_WIDTH-1:0]   sel_inc;
  logic                   sel_fin;
  logic [SUM_W-1:0]       step_sum;
  logic [SUM_W-1:0]       sweep_end;
  logic                   step_ok;
  logic [NUM_INPUTS-1:0]  finished_upd;
  logic [DWELL_WIDTH-1:0] dwell_last;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_out
    assign current_a[g*LAG_WIDTH +: LAG_WIDTH] = cur[g];
  end

  // Channel mux feeding the single shared adder/comparator.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_cur   = '0;
    sel_start = '0;
    sel_len   = '0;
    sel_inc   = '0;
    sel_fin   = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (ptr == PTR_W'(i)) begin
        sel_cur   = cur[i];
        sel_start = start_a[i*LAG_WIDTH +: LAG_WIDTH];
        sel_len   = len_a[i*LAG_WIDTH +: LAG_WIDTH];
        sel_inc   = increment_a[i*INC_WIDTH +: INC_WIDTH];
        sel_fin   = finished[i];
      end
    end
  end

  // End of sweep is computed one bit wider so start+len never wraps.
  assign step_sum   = SUM_W'(sel_cur) + SUM_W'(sel_inc);
  assign sweep_end  = SUM_W'(sel_start) + SUM_W'(sel_len);
  assign step_ok    = !sel_fin && (sel_inc != '0) && (step_sum <= sweep_end);
  assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);

  always_comb begin
    finished_upd = finished;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if ((ptr == PTR_W'(i)) && !step_ok) finished_upd[i] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge intclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      dwell_cnt <= '0;
      ptr       <= '0;
      finished  <= '0;
      frame_req <= 1'b0;
      scan_done <= 1'b0;
      busy      <= 1'b0;
      // NOTE: cur is a per-channel register bank, not a RAM, so it takes the async reset.
      for (int i = 0; i < NUM_INPUTS; i++) cur[i] <= '0;
    end else if (enable) begin
      if ((state != S_IDLE) && !capture) begin
        state     <= S_IDLE;
        frame_req <= 1'b0;
        scan_done <= 1'b0;
        finished  <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            for (int i = 0; i < NUM_INPUTS; i++) cur[i] <= start_a[i*LAG_WIDTH +: LAG_WIDTH];
            if (capture) begin
              state     <= S_DWELL;
              dwell_cnt <= '0;
              finished  <= ~scan_en;
              busy      <= 1'b1;
            end
          end

          S_DWELL: begin
            scan_done <= 1'b0;
            dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
            if (dwell_cnt == dwell_last) begin
              state     <= S_REQ;
              frame_req <= 1'b1;
            end
          end

          S_REQ: begin
            if (frame_ack) begin
              frame_req <= 1'b0;
              ptr       <= '0;
              state     <= S_ADVANCE;
            end
          end

          S_ADVANCE: begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              if ((ptr == PTR_W'(i)) && step_ok) cur[i] <= step_sum[LAG_WIDTH-1:0];
            end
            finished <= finished_upd;
            if (ptr == PTR_LAST) begin
              ptr <= '0;
              if (&finished_upd) begin
`ifdef SCAN_WRAP_EN
                // Restart the sweep; this later reload overrides the step update above.
                for (int i = 0; i < NUM_INPUTS; i++) cur[i] <= start_a[i*LAG_WIDTH +: LAG_WIDTH];
                finished  <= ~scan_en;
                scan_done <= 1'b1;
                dwell_cnt <= '0;
                state     <= S_DWELL;
`else
                scan_done <= 1'b1;
                state     <= S_DONE;
`endif
              end else begin
                dwell_cnt <= '0;
                state     <= S_DWELL;
              end
            end else begin
              ptr <= ptr + PTR_W'(1);
            end
          end

          S_DONE: scan_done <= 1'b1;

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lag_scan_scheduler.sv
// Scoreboard bench for lag_scan_scheduler: expected frame/done events are queued by the
// stimulus and popped by a monitor that snapshots current_a and the idle gap at each event.
`timescale 1ns/100ps
module tb_lag_scan_scheduler;

  localparam int N  = 2;
  localparam int LW = 20;
  localparam int IW = 12;
  localparam int DW = 24;

  typedef enum logic [1:0] {EV_FRAME = 2'd1, EV_DONE = 2'd2} ev_kind_t;
  typedef struct {
    ev_kind_t       kind;
    logic [N*LW-1:0] cur;
    int             gap;
  } ev_t;

  logic            intclk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b1;
  logic            capture = 1'b0;
  logic [N-1:0]    scan_en = '0;
  logic [N*LW-1:0] start_a = '0;
  logic [N*LW-1:0] len_a = '0;
  logic [N*IW-1:0] increment_a = '0;
  logic [DW-1:0]   dwell = '0;
  logic            frame_ack;
  logic [N*LW-1:0] current_a;
  logic            frame_req;
  logic            scan_done;
  logic            busy;

  logic ack_resp = 1'b0;
  logic ack_force = 1'b0;
  logic ack_auto = 1'b0;
  assign frame_ack = ack_resp | ack_force;

  int  checks = 0;
  int  failures = 0;
  ev_t exp_q[$];

  lag_scan_scheduler #(
    .NUM_INPUTS(N), .LAG_WIDTH(LW), .INC_WIDTH(IW), .DWELL_WIDTH(DW)
  ) dut (
    .intclk(intclk), .reset_n(reset_n), .enable(enable), .capture(capture),
    .scan_en(scan_en), .start_a(start_a), .len_a(len_a), .increment_a(increment_a),
    .dwell(dwell), .frame_ack(frame_ack), .current_a(current_a), .frame_req(frame_req),
    .scan_done(scan_done), .busy(busy)
  );

  always #5 intclk = ~intclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N*LW-1:0] lags(input int c0, input int c1);
    return {LW'(c1), LW'(c0)};
  endfunction

  task automatic expect_ev(input ev_kind_t k, input int c0, input int c1, input int gap);
    ev_t e;
    e.kind = k;
    e.cur  = lags(c0, c1);
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  // Channel 1 always carries len=3, inc=5 so a wrongly stepped disabled channel shows up.
  task automatic set_cfg(input int s0, input int l0, input int i0, input int s1,
                         input logic [N-1:0] en, input int dw);
    start_a     = lags(s0, s1);
    len_a       = lags(l0, 3);
    increment_a = {IW'(5), IW'(i0)};
    scan_en     = en;
    dwell       = DW'(dw);
  endtask

  task automatic wait_high(input bit sel_done, input int budget, input string name);
    int n;
    n = 0;
    while (((sel_done ? scan_done : frame_req) !== 1'b1) && (n < budget)) begin
      @(negedge intclk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout after %0d cycles", name, budget);
    end
  endtask

  task automatic end_test();
    capture = 1'b0;
    repeat (3) @(negedge intclk);
  endtask

  // Monitor: gap counts non-frozen-or-frozen busy cycles with frame_req low since the last event.
  initial begin
    logic prev_req, prev_done;
    int   gap;
    ev_t  e;
    prev_req  = 1'b0;
    prev_done = 1'b0;
    gap       = 0;
    forever begin
      @(negedge intclk);
      if ((frame_req && !prev_req) || (scan_done && !prev_done)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: req=%0b done=%0b cur=0x%0h", frame_req, scan_done,
                   current_a);
        end else begin
          e = exp_q.pop_front();
          check("ev_kind", 64'(frame_req && !prev_req ? EV_FRAME : EV_DONE), 64'(e.kind));
          check("ev_current", 64'(current_a), 64'(e.cur));
          check("ev_gap", 64'(gap), 64'(e.gap));
        end
        gap = 0;
      end else if (!busy) begin
        gap = 0;
      end else if (!frame_req) begin
        gap++;
      end
      prev_req  = frame_req;
      prev_done = scan_done;
    end
  end

  // Readout responder: frame_ack sampled two cycles after frame_req rises.
  initial begin
    forever begin
      @(negedge intclk);
      if (ack_auto && frame_req) begin
        @(negedge intclk);
        ack_resp = 1'b1;
        @(negedge intclk);
        ack_resp = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge intclk);
    check("rst_current", 64'(current_a), 64'(0));
    check("rst_frame_req", 64'(frame_req), 64'(0));
    check("rst_scan_done", 64'(scan_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset_n = 1'b1;
    @(negedge intclk);

    // Asynchronous reset in the middle of DWELL.
    set_cfg(10, 6, 3, 4, 2'b01, 4);
    capture = 1'b1;
    repeat (2) @(negedge intclk);
    check("pre_rst_busy", 64'(busy), 64'(1));
    check("pre_rst_current", 64'(current_a), 64'(lags(10, 4)));
    #2 reset_n = 1'b0;
    #0.5;
    check("async_rst_current", 64'(current_a), 64'(0));
    check("async_rst_frame_req", 64'(frame_req), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    capture = 1'b0;
    #0.5 reset_n = 1'b1;
    repeat (2) @(negedge intclk);

`ifdef SCAN_WRAP_EN
    // Wrapping sweep 0,1,2 repeated with a one-cycle scan_done pulse per pass.
    set_cfg(0, 2, 1, 4, 2'b01, 2);
    ack_auto = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      expect_ev(EV_FRAME, 0, 4, (pass == 0) ? 2 : 1);
      expect_ev(EV_FRAME, 1, 4, 4);
      expect_ev(EV_FRAME, 2, 4, 4);
      expect_ev(EV_DONE, 0, 4, 2);
    end
    capture = 1'b1;
    wait_high(1'b1, 200, "wrap_pulse1");
    @(negedge intclk);
    check("wrap_pulse_width", 64'(scan_done), 64'(0));
    wait_high(1'b1, 200, "wrap_pulse2");
    @(negedge intclk);
    end_test();
    ack_auto = 1'b0;
`else
    // Basic sweep: ch0 10 -> 13 -> 16, ch1 disabled holds 4.
    set_cfg(10, 6, 3, 4, 2'b01, 4);
    ack_auto = 1'b1;
    expect_ev(EV_FRAME, 10, 4, 4);
    expect_ev(EV_FRAME, 13, 4, 6);
    expect_ev(EV_FRAME, 16, 4, 6);
    expect_ev(EV_DONE, 16, 4, 2);
    capture = 1'b1;
    wait_high(1'b1, 200, "basic_done");
    repeat (4) @(negedge intclk);
    check("done_hold_scan_done", 64'(scan_done), 64'(1));
    check("done_hold_current", 64'(current_a), 64'(lags(16, 4)));
    check("done_hold_frame_req", 64'(frame_req), 64'(0));
    end_test();
    check("drop_done_scan_done", 64'(scan_done), 64'(0));
    check("drop_done_busy", 64'(busy), 64'(0));
    check("drop_done_reload", 64'(current_a), 64'(lags(10, 4)));

    // inc=0 and dwell=0: one DWELL cycle, one frame, done at start.
    set_cfg(7, 5, 0, 4, 2'b01, 0);
    expect_ev(EV_FRAME, 7, 4, 1);
    expect_ev(EV_DONE, 7, 4, 2);
    capture = 1'b1;
    wait_high(1'b1, 100, "inc0_done");
    @(negedge intclk);
    end_test();

    // Freeze for 5 cycles in DWELL with a stray frame_ack: frame_req shifts by 5.
    set_cfg(20, 0, 1, 4, 2'b01, 4);
    expect_ev(EV_FRAME, 20, 4, 9);
    expect_ev(EV_DONE, 20, 4, 2);
    capture = 1'b1;
    repeat (2) @(negedge intclk);
    enable = 1'b0;
    repeat (2) @(negedge intclk);
    ack_force = 1'b1;
    @(negedge intclk);
    ack_force = 1'b0;
    repeat (2) @(negedge intclk);
    check("frozen_busy", 64'(busy), 64'(1));
    check("frozen_frame_req", 64'(frame_req), 64'(0));
    enable = 1'b1;
    wait_high(1'b1, 100, "freeze_done");
    @(negedge intclk);
    end_test();
    ack_auto = 1'b0;

    // Capture dropped while frame_req is high.
    set_cfg(10, 6, 3, 4, 2'b01, 4);
    expect_ev(EV_FRAME, 10, 4, 4);
    expect_ev(EV_FRAME, 13, 4, 6);
    capture = 1'b1;
    wait_high(1'b0, 50, "drop_req1");
    ack_force = 1'b1;
    @(negedge intclk);
    ack_force = 1'b0;
    wait_high(1'b0, 50, "drop_req2");
    capture = 1'b0;
    @(negedge intclk);
    check("drop_frame_req", 64'(frame_req), 64'(0));
    check("drop_busy", 64'(busy), 64'(0));
    check("drop_current_hold", 64'(current_a), 64'(lags(13, 4)));
    @(negedge intclk);
    check("drop_current_reload", 64'(current_a), 64'(lags(10, 4)));
    ack_force = 1'b1;
    @(negedge intclk);
    ack_force = 1'b0;
    repeat (2) @(negedge intclk);
    check("late_ack_frame_req", 64'(frame_req), 64'(0));
    check("late_ack_busy", 64'(busy), 64'(0));
`endif

    repeat (5) @(negedge intclk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
